supersample_buffer: RTL and testbench
=====================================

# supersample_buffer

Chroma up-sampling buffer for the 4:2:0 JPEG decode path, placed after IDCT/level-shift and before colour conversion. It collects one MCU of decoded 8×8 blocks (Y0, Y1, Y2, Y3, Cb, Cr), snapshots it, and emits four full-resolution 8×8 triplets. Each triplet is one Y block plus the matching Cb/Cr quadrant, up-sampled 2× by pixel replication.

## Interface
- Parameter `Q`, default 8: output sample width in bits; must be ≥ 8.
- Parameter `CH`, default 3: number of colour channels; sets the `ch_in` width.
- `clk` in, 1 bit: clock; all state changes on the rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-high.
- `valid_in` in, 1 bit: `block_in`/`ch_in` valid this cycle; there is no back-pressure.
- `ch_in` in, $clog2(CH+1) bits (2): 0 = Y, 1 = Cb, 2 = Cr; 3 is ignored.
- `block_in` in, [7:0][7:0] × 8 bits: input block, indexed [row][col], row 0 = top, col 0 = left.
- `y_out` out, [7:0][7:0] × Q bits: luma block.
- `cb_out` out, [7:0][7:0] × Q bits: up-sampled Cb.
- `cr_out` out, [7:0][7:0] × Q bits: up-sampled Cr.
- `valid_out` out, 1 bit: the output triplet is valid.

## Operation
- Capture bank: 4 Y slots, 1 Cb slot, 1 Cr slot, each 64×8 bits. `y_idx` is a 2-bit slot counter.
- When `valid_in` is high and `ch_in` = 0: write Y slot `y_idx`, then `y_idx` += 1 (wraps 3 → 0).
- When `valid_in` is high and `ch_in` = 1: write the Cb slot.
- When `valid_in` is high and `ch_in` = 2: the MCU is complete.
  - Copy Y0..Y3 and Cb into the output snapshot bank.
  - Copy `block_in` directly into the snapshot Cr slot.
  - Set `out_k` = 0, set `valid_out` = 1, clear `y_idx`.
- Y order inside an MCU: k = 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- Output for triplet k, combinational from the snapshot and `out_k`:
  - `y_out[r][c]` = Yk[r][c].
  - `cb_out[r][c]` = Cb[4·(k>>1) + r/2][4·(k&1) + c/2]; `cr_out` likewise from Cr.
  - All values are zero-extended from 8 to Q bits.
- Emission FSM states: IDLE and EMIT.
  - EMIT: `out_k` increments each cycle; after k = 3 the FSM returns to IDLE and `valid_out` drops.
  - A new MCU completion during EMIT reloads the snapshot and restarts at k = 0, abandoning the rest of the old emission.
- In IDLE the outputs hold the last emitted triplet (`out_k` stays 3).
- Capture and emission are independent, so MCUs may arrive back-to-back (6 consecutive `valid_in` cycles) with no gaps.

## Timing
- Reset (asynchronous) clears all slots, snapshots and counters. After reset: `y_out`, `cb_out`, `cr_out` all zero, `valid_out` = 0, FSM in IDLE.
- Cr accepted at rising edge N: `valid_out` is high in the cycles following edges N, N+1, N+2 and N+3, carrying k = 0, 1, 2, 3.
- Reset asserted mid-MCU or mid-emission: the partial MCU is discarded and `valid_out` drops immediately.
- Latency from the Cr block to the first triplet is 1 edge. Throughput is 1 triplet per cycle.

## Configuration
- `SUPERSAMPLE_SEQ_CHECK_EN` defined:
  - Capture enforces the strict order Y, Y, Y, Y, Cb, Cr using a 3-bit position counter.
  - A valid block whose `ch_in` does not match the expected channel is dropped; the counter resets to 0.
  - If the dropped block has `ch_in` = 0, it is accepted as Y0 and the counter moves to 1.
  - A Cr block only triggers emission when it arrives in position 5.
- Not defined: no checking. Blocks are placed by `ch_in` as described in Operation, and every Cr block triggers emission.

## Test plan
- Reset for 2 cycles, `valid_in` = 0 → all outputs 0 and `valid_out` = 0 for 15 cycles.
- One MCU with Y0..Y3, Cb, Cr blocks whose pixel = base + raster offset, bases 1, 2, 3, 4, 5, 6 → `valid_out` high for exactly 4 cycles starting one cycle after the Cr edge.
  - k = 0: `y_out` equals the Y0 block.
  - k = 0: `cb_out[0][0]` = `cb_out[1][1]` = Cb[0][0].
  - k = 3: `cb_out[7][7]` = Cb[7][7].
  - Upper Q−8 bits of every output are 0.
- Two MCUs back-to-back with no gaps → two 4-cycle bursts 6 cycles apart. The second MCU's Y writes never corrupt the first burst's data.
- Cr block arriving during EMIT (checking disabled) → burst restarts at k = 0 with the new data.
- Reset asserted during the k = 1 cycle → `valid_out` is 0 immediately and outputs are 0.
- With `SUPERSAMPLE_SEQ_CHECK_EN`: sequence Y, Y, Cb, … → the Cb block is dropped and no emission happens until a full ordered 6-block sequence is received.

Source files
------------

// File: rtl/supersample_buffer.sv
// supersample_buffer: 4:2:0 chroma up-sampling buffer. Collects one MCU
// (Y0..Y3, Cb, Cr), snapshots it and emits four full-resolution triplets.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   valid_in       - block_in/ch_in valid (no back-pressure)
//   ch_in          - 0 = Y, 1 = Cb, 2 = Cr, 3 = ignored
//   block_in       - 8x8 input block [row][col]
//   y_out          - luma block of triplet k
//   cb_out, cr_out - 2x replicated chroma quadrant of triplet k
//   valid_out      - output triplet valid
// Optional: SUPERSAMPLE_SEQ_CHECK_EN enforces strict Y,Y,Y,Y,Cb,Cr order.
module supersample_buffer #(
   parameter int Q  = 8,
   parameter int CH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [$clog2(CH+1)-1:0]    ch_in,
   input  logic [7:0][7:0][7:0]       block_in,
   output logic [7:0][7:0][Q-1:0]     y_out,
   output logic [7:0][7:0][Q-1:0]     cb_out,
   output logic [7:0][7:0][Q-1:0]     cr_out,
   output logic                       valid_out
);

   localparam int CW = $clog2(CH+1);

   typedef logic [7:0][7:0][7:0] blk_t;
   typedef enum logic {IDLE, EMIT} state_t;

   blk_t   cap_y [4];
   blk_t   cap_cb;
   blk_t   snap_y [4];
   blk_t   snap_cb;
   blk_t   snap_cr;

   state_t     state, next_state;
   logic [1:0] out_k, next_k;

   logic       fire;
   logic       wr_y;
   logic       wr_cb;
   logic [1:0] wr_idx;

`ifdef SUPERSAMPLE_SEQ_CHECK_EN
   logic [2:0]    pos;
   logic [CW-1:0] exp_ch;
   logic          match;

   always_comb begin
      exp_ch = (pos < 3'd4)  ? CW'(0) :
               (pos == 3'd4) ? CW'(1) : CW'(2);
      match  = valid_in && (ch_in == exp_ch);
      fire   = match && (ch_in == CW'(2));
      // An out-of-order Y restarts the MCU as its Y0.
      wr_y   = valid_in && (ch_in == CW'(0));
      wr_idx = match ? pos[1:0] : 2'd0;
      wr_cb  = match && (ch_in == CW'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= 3'd0;
      end else if (valid_in && (ch_in != CW'(3))) begin
         if (match)
            pos <= fire ? 3'd0 : pos + 3'd1;
         else
            pos <= (ch_in == CW'(0)) ? 3'd1 : 3'd0;
      end
   end
`else
   logic [1:0] y_idx;

   always_comb begin
      fire   = valid_in && (ch_in == CW'(2));
      wr_y   = valid_in && (ch_in == CW'(0));
      wr_idx = y_idx;
      wr_cb  = valid_in && (ch_in == CW'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         y_idx <= 2'd0;
      else if (fire)
         y_idx <= 2'd0;
      else if (wr_y)
         y_idx <= y_idx + 2'd1;
   end
`endif

   // Capture and snapshot banks; snapshot decouples emission from capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            cap_y[i]  <= '0;
            snap_y[i] <= '0;
         end
         cap_cb  <= '0;
         snap_cb <= '0;
         snap_cr <= '0;
      end else begin
         if (wr_y)
            cap_y[wr_idx] <= block_in;
         if (wr_cb)
            cap_cb <= block_in;
         if (fire) begin
            snap_y  <= cap_y;
            snap_cb <= cap_cb;
            snap_cr <= block_in;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         out_k <= 2'd0;
      end else begin
         state <= next_state;
         out_k <= next_k;
      end
   end

   always_comb begin
      next_state = state;
      next_k     = out_k;
      if (fire) begin
         next_state = EMIT;
         next_k     = 2'd0;
      end else begin
         unique case (state)
            IDLE: ;
            EMIT: begin
               if (out_k == 2'd3)
                  next_state = IDLE;
               else
                  next_k = out_k + 2'd1;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   assign valid_out = (state == EMIT);

   // Triplet k picks quadrant row k[1], column k[0]; each chroma
   // sample is replicated over a 2x2 output patch.
   always_comb begin
      logic [2:0] ri;
      logic [2:0] ci;
      y_out  = '0;
      cb_out = '0;
      cr_out = '0;
      ri     = '0;
      ci     = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            ri = {out_k[1], 2'(r / 2)};
            ci = {out_k[0], 2'(c / 2)};
            y_out[r][c]  = Q'(snap_y[out_k][r][c]);
            cb_out[r][c] = Q'(snap_cb[ri][ci]);
            cr_out[r][c] = Q'(snap_cr[ri][ci]);
         end
      end
   end

endmodule

// File: tb/tb_supersample_buffer.sv
// tb_supersample_buffer: scoreboard bench for supersample_buffer with a
// high-level MCU model, randomized block data, gaps and channel streams.
module tb_supersample_buffer;

   localparam int Q = 10;

   typedef logic [7:0][7:0][7:0]   blk_t;
   typedef logic [7:0][7:0][Q-1:0] oblk_t;
   typedef struct {
      int    cyc;
      int    k;
      oblk_t y;
      oblk_t cb;
      oblk_t cr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  ch_in;
   blk_t        block_in;
   oblk_t       y_out, cb_out, cr_out;
   logic        valid_out;

   supersample_buffer #(.Q(Q), .CH(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ch_in     (ch_in),
      .block_in  (block_in),
      .y_out     (y_out),
      .cb_out    (cb_out),
      .cr_out    (cr_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   exp_t  sbq[$];
   oblk_t hy, hcb, hcr;

   blk_t my [4];
   blk_t mcb;
   int   yi;
   int   pos;

   function automatic oblk_t ext(input blk_t b);
      oblk_t o;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            o[r][c] = Q'(b[r][c]);
      return o;
   endfunction

   function automatic oblk_t up(input blk_t b, input int k);
      oblk_t o;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            o[r][c] = Q'(b[4 * (k / 2) + r / 2][4 * (k % 2) + c / 2]);
      return o;
   endfunction

   function automatic blk_t rnd_blk();
      blk_t b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r][c] = 8'($urandom);
      return b;
   endfunction

   function automatic blk_t base_blk(input int base);
      blk_t b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r][c] = 8'(base + r * 8 + c);
      return b;
   endfunction

   task automatic model_emit(input blk_t cr);
      exp_t e;
      // A new MCU abandons whatever of the previous burst is still pending.
      while (sbq.size() > 0 && sbq[$].cyc > cyc)
         void'(sbq.pop_back());
      for (int k = 0; k < 4; k++) begin
         e.cyc = cyc + 1 + k;
         e.k   = k;
         e.y   = ext(my[k]);
         e.cb  = up(mcb, k);
         e.cr  = up(cr, k);
         sbq.push_back(e);
      end
   endtask

   task automatic model_accept(input int ch, input blk_t b);
`ifdef SUPERSAMPLE_SEQ_CHECK_EN
      int want;
      want = (pos < 4) ? 0 : (pos == 4) ? 1 : 2;
      if (ch == 3) begin
      end else if (ch == want) begin
         if (ch == 0) my[pos] = b;
         if (ch == 1) mcb = b;
         if (ch == 2) model_emit(b);
         pos = (ch == 2) ? 0 : pos + 1;
      end else if (ch == 0) begin
         my[0] = b;
         pos   = 1;
      end else begin
         pos = 0;
      end
`else
      if (ch == 0) begin
         my[yi] = b;
         yi     = (yi + 1) % 4;
      end else if (ch == 1) begin
         mcb = b;
      end else if (ch == 2) begin
         model_emit(b);
         yi = 0;
      end
`endif
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) my[i] = '0;
      mcb = '0;
      yi  = 0;
      pos = 0;
      sbq.delete();
      hy  = '0;
      hcb = '0;
      hcr = '0;
   endtask

   // Called at a negedge; returns at the next negedge with valid_in low.
   task automatic send(input int ch, input blk_t b);
      valid_in = 1'b1;
      ch_in    = 2'(ch);
      block_in = b;
      model_accept(ch, b);
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_mcu(input int gap_max);
      for (int i = 0; i < 6; i++) begin
         send((i < 4) ? 0 : i - 4, rnd_blk());
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
      end
   endtask

   task automatic chk_blk(input string nm, input oblk_t act, input oblk_t req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", nm, act, req);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            $display("FAIL missed_triplet k=%0d actual valid_out=0 required=1 cyc=%0d",
                     sbq[0].k, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (valid_out) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
               e = sbq.pop_front();
               chk_blk($sformatf("y_k%0d", e.k), y_out, e.y);
               chk_blk($sformatf("cb_k%0d", e.k), cb_out, e.cb);
               chk_blk($sformatf("cr_k%0d", e.k), cr_out, e.cr);
               hy  = e.y;
               hcb = e.cb;
               hcr = e.cr;
            end else begin
               checks++;
               $display("FAIL spurious_valid actual=1 required=0 cyc=%0d", cyc);
            end
         end else begin
            chk_blk("hold_y", y_out, hy);
            chk_blk("hold_cb", cb_out, hcb);
            chk_blk("hold_cr", cr_out, hcr);
         end
      end
   end

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      ch_in    = 2'd0;
      block_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(15);

      // Directed MCU: bases 1..6 with raster offsets.
      for (int i = 0; i < 6; i++)
         send((i < 4) ? 0 : i - 4, base_blk(i + 1));
      idle(8);

      // Two MCUs back-to-back, no gaps.
      send_mcu(0);
      send_mcu(0);
      idle(8);

`ifndef SUPERSAMPLE_SEQ_CHECK_EN
      // Cr during emission restarts the burst with new data.
      send_mcu(0);
      send(1, rnd_blk());
      send(2, rnd_blk());
      idle(8);
`endif

      // Reset during the k = 1 cycle.
      send_mcu(0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (valid_out === 1'b0) passed++;
      else $display("FAIL rst_valid actual=%b required=0", valid_out);
      chk_blk("rst_y", y_out, '0);
      chk_blk("rst_cb", cb_out, '0);
      chk_blk("rst_cr", cr_out, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(4);

`ifdef SUPERSAMPLE_SEQ_CHECK_EN
      // Out-of-order Cb is dropped; only a full ordered MCU emits.
      send(0, rnd_blk());
      send(0, rnd_blk());
      send(1, rnd_blk());
      send(2, rnd_blk());
      idle(6);
      send_mcu(0);
      idle(6);
`endif

      // Randomized MCUs with random gaps.
      for (int m = 0; m < 15; m++) send_mcu(3);
      idle(8);

      // Random channel stream (includes ignored channel 3).
      for (int i = 0; i < 80; i++) begin
         send($urandom_range(3, 0), rnd_blk());
         if ($urandom_range(3, 0) == 0) idle(1);
      end
      idle(8);

      checks++;
      if (sbq.size() == 0) passed++;
      else $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
